pled_fade_sequencer: RTL

Sequencer for the Pmod power-LED board. It schedules a breathing pattern across the red, green and blue channels. A timer prescaler, a PWM period counter and a four-phase fade state machine step the shared duty level up and down. After each breath it advances to the next colour mix. It sits between the board clock and the three active-low LED driver pins, and replaces free-running per-design fade logic.

---
 rtl/pled_fade_sequencer_if.sv | 24 ++
 rtl/pled_fade_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pled_fade_sequencer_if.sv
// Run-enable and LED-drive bundle between the fade sequencer and its host.
// The host side (master) drives en and observes the registered outputs.
interface pled_fade_sequencer_if #(
  parameter int PWM_BITS = 10
);
  logic                en;
  logic                red;
  logic                green;
  logic                blue;
  logic [PWM_BITS-1:0] duty;
  logic [2:0]          color;
  logic [1:0]          phase;
  logic                period_end;

  modport master (
    output en,
    input  red, green, blue, duty, color, phase, period_end
  );

  modport slave (
    input  en,
    output red, green, blue, duty, color, phase, period_end
  );
endinterface

// File: rtl/pled_fade_sequencer.sv
// Breathing-pattern sequencer for the Pmod power-LED board: prescaler, PWM counter and
// fade FSM share one duty level, which is applied to the active-low pins of the current colour mix.
module pled_fade_sequencer #(
  parameter int TICK_DIV     = 500,
  parameter int PWM_BITS     = 10,
  parameter int RAMP_PERIODS = 1,
  parameter int HOLD_PERIODS = 64,
  parameter int MIN_DUTY     = 32,
  parameter int MAX_DUTY     = 1023,
  parameter int STEP_KNEE    = 256,
  parameter int STEP_FINE    = 1,
  parameter int STEP_COARSE  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pled_fade_sequencer_if.slave bus
);

  localparam int PRE_W  = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
  localparam int STEP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  typedef logic [PWM_BITS-1:0] duty_t;
  typedef logic [PWM_BITS:0]   wide_t;

  // HOLD_LOW shares the PH_IDLE code and is told apart by busy.
  typedef enum logic [1:0] {
    PH_IDLE      = 2'd0,
    PH_RAMP_UP   = 2'd1,
    PH_HOLD_HIGH = 2'd2,
    PH_RAMP_DOWN = 2'd3
  } phase_t;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_PERIODS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
  localparam duty_t MIN_D    = duty_t'(MIN_DUTY);
  localparam duty_t MAX_D    = duty_t'(MAX_DUTY);
  localparam wide_t MIN_W    = wide_t'(MIN_DUTY);
  localparam wide_t MAX_W    = wide_t'(MAX_DUTY);
  localparam wide_t KNEE_W   = wide_t'(STEP_KNEE);
  localparam wide_t FINE_W   = wide_t'(STEP_FINE);
  localparam wide_t COARSE_W = wide_t'(STEP_COARSE);

  phase_t            phase;
  logic              busy;
  logic [PRE_W-1:0]  presc;
  duty_t             pwm_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  duty_t             duty;
  logic [2:0]        color;
  logic              red, green, blue;
  logic              period_end;

  logic  tick, wrap, step_evt, hold_done, lit;
  logic  up_ceil, dn_floor;
  wide_t duty_w, step_w, up_w;
  duty_t dn_d;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    tick      = (presc == PRE_LAST);
    wrap      = tick && (pwm_cnt == '1);
    step_evt  = wrap && (step_cnt == STEP_LAST);
    hold_done = wrap && (hold_cnt == HOLD_LAST);
    lit       = (pwm_cnt < duty);
    duty_w    = {1'b0, duty};
    step_w    = (duty_w < KNEE_W) ? FINE_W : COARSE_W;
    up_w      = duty_w + step_w;
    dn_d      = duty_t'(duty_w - step_w);
    up_ceil   = (up_w >= MAX_W);
    // Compare before subtracting so a step larger than duty cannot wrap below zero.
    dn_floor  = (duty_w <= MIN_W + step_w);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      phase      <= PH_IDLE;
      busy       <= 1'b0;
      presc      <= '0;
      pwm_cnt    <= '0;
      step_cnt   <= '0;
      hold_cnt   <= '0;
      duty       <= MIN_D;
      color      <= 3'b001;
      red        <= 1'b1;
      green      <= 1'b1;
      blue       <= 1'b1;
      period_end <= 1'b0;
    end else if (!busy) begin
      phase <= PH_RAMP_UP;
      busy  <= 1'b1;
    end else begin
      presc      <= tick ? '0 : presc + 1'b1;
      period_end <= wrap;
      red        <= !(lit && color[0]);
      green      <= !(lit && color[1]);
      blue       <= !(lit && color[2]);
      if (tick)
        pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap)
        step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;

      unique case (phase)
        PH_RAMP_UP: begin
          if (step_evt) begin
            if (up_ceil) begin
              duty     <= MAX_D;
              phase    <= PH_HOLD_HIGH;
              hold_cnt <= '0;
            end else begin
              duty <= up_w[PWM_BITS-1:0];
            end
          end
        end
        PH_HOLD_HIGH: begin
          if (hold_done)
            phase <= PH_RAMP_DOWN;
          else if (wrap)
            hold_cnt <= hold_cnt + 1'b1;
        end
        PH_RAMP_DOWN: begin
          if (step_evt) begin
            if (dn_floor) begin
              duty     <= MIN_D;
              phase    <= PH_IDLE;
              hold_cnt <= '0;
            end else begin
              duty <= dn_d;
            end
          end
        end
        PH_IDLE: begin
          // busy is set here, so this is HOLD_LOW; the breath ends with the next colour mix.
          if (hold_done) begin
            color <= (color == 3'd7) ? 3'd1 : color + 3'd1;
            phase <= PH_RAMP_UP;
          end else if (wrap) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.red        = red;
  assign bus.green      = green;
  assign bus.blue       = blue;
  assign bus.duty       = duty;
  assign bus.color      = color;
  assign bus.phase      = phase;
  assign bus.period_end = period_end;

endmodule
